// File: rtl/gates_pkg.sv
// Shared constants and types for the gates block and its built-in self-test.
package gates_pkg;

  localparam int unsigned Z_W         = 8;
  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned VEC_W       = 2;

  // Output bit positions on gates.Z_out
  typedef enum int unsigned {
    Z_AND  = 0,
    Z_OR   = 1,
    Z_NAND = 2,
    Z_NOR  = 3,
    Z_XOR  = 4,
    Z_XNOR = 5,
    Z_NOTA = 6,
    Z_NOTB = 7
  } z_bit_e;

  // Gray-ordered stimulus: (0,0) (0,1) (1,1) (1,0), element [v] is vector v
  localparam logic [NUM_VECTORS-1:0] VEC_A = 4'b1100;
  localparam logic [NUM_VECTORS-1:0] VEC_B = 4'b0110;
  localparam logic [NUM_VECTORS-1:0][Z_W-1:0] EXP_Z = {8'h96, 8'h23, 8'h56, 8'hEC};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic           a;
    logic           b;
    logic [Z_W-1:0] z;
  } vec_t;

endpackage

// File: rtl/gates_golden.sv
// Golden stimulus/response lookup: vector index -> {a, b, expected Z}.
module gates_golden
  import gates_pkg::*;
(
  input  logic [VEC_W-1:0] idx,
  output vec_t             vec_c
);

  always_comb begin
    vec_c.a = VEC_A[idx];
    vec_c.b = VEC_B[idx];
    vec_c.z = EXP_Z[idx];
  end

endmodule

// File: rtl/gates_bist.sv
// Self-test sequencer: walks the four input vectors through gates, samples Z
// after a settle time and accumulates pass/fail, mismatch mask and error count.
module gates_bist
  import gates_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [Z_W-1:0]   z_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             result_valid_out,
  output logic             pass_out,
  output logic [Z_W-1:0]   fail_mask_out,
  output logic [2:0]       err_count_out,
  output logic [VEC_W-1:0] first_fail_out
);

  localparam int unsigned      CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] IDX_LAST = VEC_W'(NUM_VECTORS - 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [VEC_W-1:0]  idx, idx_nxt;
  logic [Z_W-1:0]    exp_z;
  vec_t              nxt_vec_c;

  logic              a_nxt, b_nxt, busy_nxt, done_nxt, rv_nxt, pass_nxt;
  logic [Z_W-1:0]    fail_mask_nxt, mism_c;
  logic [2:0]        err_nxt;
  logic [VEC_W-1:0]  first_fail_nxt;

  // Golden lookup indexed by the upcoming vector so pins and reference load together
  gates_golden u_golden (
    .idx   (idx_nxt),
    .vec_c (nxt_vec_c)
  );

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    idx_nxt        = idx;
    mism_c         = '0;
    fail_mask_nxt  = fail_mask_out;
    err_nxt        = err_count_out;
    first_fail_nxt = first_fail_out;
    pass_nxt       = pass_out;
    rv_nxt         = result_valid_out;

    case (state)
      ST_IDLE: begin
        if (start_in) begin
          state_nxt      = ST_DRIVE;
          cnt_nxt        = '0;
          idx_nxt        = '0;
          fail_mask_nxt  = '0;
          err_nxt        = '0;
          first_fail_nxt = '0;
          pass_nxt       = 1'b0;
          rv_nxt         = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (cnt == CNT_LAST) state_nxt = ST_SAMPLE;
        else                 cnt_nxt   = cnt + CNT_W'(1);
      end
      ST_SAMPLE: begin
        mism_c        = z_in ^ exp_z;
        fail_mask_nxt = fail_mask_out | mism_c;
        if (|mism_c) begin
          err_nxt = err_count_out + 3'd1;
          if (err_count_out == 3'd0) first_fail_nxt = idx;
        end
        if (idx == IDX_LAST) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_DRIVE;
          idx_nxt   = idx + VEC_W'(1);
          cnt_nxt   = '0;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    // Results are published on entry to DONE so they are visible during it
    if (state_nxt == ST_DONE) begin
      pass_nxt = (err_nxt == 3'd0);
      rv_nxt   = 1'b1;
    end

    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_DONE);
    a_nxt    = ((state_nxt == ST_DRIVE) || (state_nxt == ST_SAMPLE)) && nxt_vec_c.a;
    b_nxt    = ((state_nxt == ST_DRIVE) || (state_nxt == ST_SAMPLE)) && nxt_vec_c.b;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      idx              <= '0;
      exp_z            <= '0;
      a_out            <= 1'b0;
      b_out            <= 1'b0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
      result_valid_out <= 1'b0;
      pass_out         <= 1'b0;
      fail_mask_out    <= '0;
      err_count_out    <= '0;
      first_fail_out   <= '0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      idx              <= idx_nxt;
      exp_z            <= nxt_vec_c.z;
      a_out            <= a_nxt;
      b_out            <= b_nxt;
      busy_out         <= busy_nxt;
      done_out         <= done_nxt;
      result_valid_out <= rv_nxt;
      pass_out         <= pass_nxt;
      fail_mask_out    <= fail_mask_nxt;
      err_count_out    <= err_nxt;
      first_fail_out   <= first_fail_nxt;
    end
  end

endmodule
